// File: rtl/mux2x32_pkg.sv
// Shared word definitions for the 2:1 word multiplexer.
package mux2x32_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mux2x32_core.sv
// Combinational 2:1 select, built as independent per-bit selects.
module mux2x32_core
    import mux2x32_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    output logic [WIDTH-1:0] y,
    input  logic             s,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Only a definite 1 picks a1; an unknown select falls back to a0.
        assign y[i] = (s === 1'b1) ? a1[i] : a0[i];
    end
endmodule

// File: rtl/mux2x32.sv
// 2:1 word mux with an optional reset-able output register for retiming.
module mux2x32
    import mux2x32_pkg::*;
#(
    parameter int               WIDTH     = WORD_W,
    parameter bit               OUT_REG   = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y,
    input  logic             s,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1
);
    logic [WIDTH-1:0] y_d;

    mux2x32_core #(.WIDTH(WIDTH)) u_core (
        .y  (y_d),
        .s  (s),
        .a0 (a0),
        .a1 (a1)
    );

    if (OUT_REG) begin : g_reg
        logic [WIDTH-1:0] y_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) y_q <= RESET_VAL;
            else     y_q <= y_d;
        end

        assign y = y_q;
    end else begin : g_comb
        // Clock and reset have no effect on the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign y = y_d;
    end
endmodule

// File: tb/tb_mux2x32.sv
// Scoreboard bench for mux2x32 in combinational and registered builds.
module tb_mux2x32;
    import mux2x32_pkg::*;

    logic  clk;
    logic  rst;
    logic  s;
    word_t a0, a1;
    word_t y_c, y_r;

    int checks = 0;
    int errors = 0;
    word_t cq[$];
    word_t rq[$];
    word_t exp_v;

    mux2x32 #(.OUT_REG(1'b0)) u_comb (
        .clk(clk), .rst(rst), .y(y_c), .s(s), .a0(a0), .a1(a1)
    );
    mux2x32 #(.OUT_REG(1'b1), .RESET_VAL(32'h0)) u_reg (
        .clk(clk), .rst(rst), .y(y_r), .s(s), .a0(a0), .a1(a1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t ref_mux(input logic sel, input word_t x0, input word_t x1);
        word_t m;
        m = {WORD_W{sel === 1'b1}};
        return (x1 & m) | (x0 & ~m);
    endfunction

    task automatic test_reset();
        rst = 1'b1; s = 1'b1; a0 = 32'h0; a1 = 32'hDEADBEEF;
        #1;
        checks++;
        if (y_r !== 32'h0) begin
            errors++; $display("FAIL reset_no_clk: got %h expected %h", y_r, 32'h0);
        end
        checks++;
        if (y_c !== 32'hDEADBEEF) begin
            errors++; $display("FAIL comb_ignores_rst: got %h expected %h", y_c, 32'hDEADBEEF);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (y_r !== 32'h0) begin
            errors++; $display("FAIL reset_hold: got %h expected %h", y_r, 32'h0);
        end
    endtask

    task automatic test_corners();
        word_t p0[4] = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
        word_t p1[4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                s = k[0]; a0 = p0[i]; a1 = p1[i];
                cq.push_back(k == 0 ? p0[i] : p1[i]);
                #1;
                exp_v = cq.pop_front();
                checks++;
                if (y_c !== exp_v) begin
                    errors++; $display("FAIL corner%0d_s%0d: got %h expected %h", i, k, y_c, exp_v);
                end
            end
        end
    endtask

    task automatic test_patterns();
        a0 = 32'hA5A5A5A5; a1 = 32'h5A5A5A5A; s = 1'b0;
        cq.push_back(32'hA5A5A5A5);
        #1;
        exp_v = cq.pop_front();
        checks++;
        if (y_c !== exp_v) begin
            errors++; $display("FAIL pattern_s0: got %h expected %h", y_c, exp_v);
        end
        s = 1'b1;
        cq.push_back(32'h5A5A5A5A);
        #0;
        exp_v = cq.pop_front();
        checks++;
        if (y_c !== exp_v) begin
            errors++; $display("FAIL pattern_s1_same_step: got %h expected %h", y_c, exp_v);
        end
        #1;
    endtask

    task automatic test_sel_x();
        s = 1'bx; a0 = 32'h12345678; a1 = 32'h9ABCDEF0;
        cq.push_back(32'h12345678);
        #1;
        exp_v = cq.pop_front();
        checks++;
        if (y_c !== exp_v) begin
            errors++; $display("FAIL sel_x: got %h expected %h", y_c, exp_v);
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst = 1'b0; s = 1'b1; a0 = 32'h0; a1 = 32'hDEADBEEF;
        rq.push_back(32'hDEADBEEF);
        #1;
        checks++;
        if (y_r !== 32'h0) begin
            errors++; $display("FAIL reg_not_before_edge: got %h expected %h", y_r, 32'h0);
        end
        @(posedge clk);
        #1;
        exp_v = rq.pop_front();
        checks++;
        if (y_r !== exp_v) begin
            errors++; $display("FAIL reg_first_capture: got %h expected %h", y_r, exp_v);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        rq.delete();
        #1;
        checks++;
        if (y_r !== 32'h0) begin
            errors++; $display("FAIL mid_reset_immediate: got %h expected %h", y_r, 32'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (y_r !== 32'h0) begin
            errors++; $display("FAIL mid_reset_hold: got %h expected %h", y_r, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            s  = $urandom_range(1, 0) == 1;
            a0 = $urandom;
            a1 = $urandom;
            cq.push_back(ref_mux(s, a0, a1));
            rq.push_back(ref_mux(s, a0, a1));
            #1;
            exp_v = cq.pop_front();
            checks++;
            if (y_c !== exp_v) begin
                errors++; $display("FAIL rand_comb[%0d]: got %h expected %h", n, y_c, exp_v);
            end
            @(posedge clk);
            #1;
            exp_v = rq.pop_front();
            checks++;
            if (y_r !== exp_v) begin
                errors++; $display("FAIL rand_reg[%0d]: got %h expected %h", n, y_r, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_patterns();
        test_sel_x();
        test_registered();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
